ifu_pf: RTL
===========

# ifu_pf

Parametrised prefetching instruction fetch unit. Sits between the decode/execute unit and the instruction memory port. It issues sequential fetches ahead of execution and keeps up to `MAX_OS` requests in flight. Returned instructions go into a `DEPTH`-entry in-order buffer. A redirect flushes the buffer and discards stale responses. Until an instruction is available, it presents `jal x0,0` as a non-valid filler.

## Interface
Parameters:
- `ADDR_W`, 32, instruction address width
- `DATA_W`, 32, instruction width
- `DEPTH`, 4, prefetch buffer entries; power of 2, ≥2
- `MAX_OS`, 2, maximum outstanding memory requests, including ones to be discarded; 1..DEPTH
- `RST_PC`, 32'h0000_0000, reset fetch address
- `INST_NOP`, 32'h0000_006f, filler instruction driven when the buffer is empty

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `redirect_i` in 1: flush and restart fetch at `redirect_pc_i`
- `redirect_pc_i` in ADDR_W: new PC; bits [1:0] are forced to 0
- `inst_nxt_i` in 1: consumer takes the head instruction this cycle
- `pc_o` out ADDR_W: PC of the head instruction
- `inst_o` out DATA_W: head instruction, or `INST_NOP` when the buffer is empty
- `inst_valid_o` out 1: head instruction is valid
- `if_req_o` out 1: fetch request
- `if_addr_o` out ADDR_W: fetch address
- `if_gnt_i` in 1: request accepted this cycle
- `if_ack_i` in 1: read data valid; responses return in order, at most one per cycle
- `if_data_i` in DATA_W: read data

## Operation
Registers:
- `fetch_pc`: next address to request
- `exp_pc`: PC of the head instruction
- `os_cnt`: outstanding requests, range 0..MAX_OS
- `disc_cnt`: stale responses still to be dropped, with disc_cnt ≤ os_cnt
- FIFO: DATA_W × DEPTH, with `cnt`, read pointer and write pointer

Request issue:
- if_req_o = !rst & !redirect_i & (os_cnt < MAX_OS) & (os_cnt + cnt < DEPTH)
- The `os_cnt + cnt < DEPTH` term is the credit check; it guarantees the FIFO never overflows.
- if_addr_o = fetch_pc.
- On req & gnt: fetch_pc += 4, modulo 2^ADDR_W, and os_cnt increments.
- Once raised, req and addr stay stable until gnt. The only exception is a redirect, which may drop the request.

Response handling:
- On ack with disc_cnt > 0: the data is dropped and disc_cnt decrements.
- On ack otherwise: the data is pushed into the FIFO.
- Every ack decrements os_cnt. In a cycle with both gnt and ack, os_cnt is unchanged.

Consume:
- inst_valid_o = (cnt ≠ 0); inst_o = FIFO head, or INST_NOP if empty; pc_o = exp_pc.
- Pop happens on inst_nxt_i & inst_valid_o; exp_pc += 4 on pop.
- inst_nxt_i while empty is ignored.

Redirect:
- The FIFO empties.
- fetch_pc and exp_pc are loaded with {redirect_pc_i[ADDR_W-1:2], 2'b00}.
- disc_cnt is loaded with os_cnt − ack, where ack is if_ack_i this cycle.
- os_cnt is loaded with os_cnt − ack.
- An ack arriving in the redirect cycle is dropped.
- Redirect wins over a simultaneous pop and a simultaneous push.

No stall or ack-timeout state exists; the memory port guarantees every granted request gets an ack.

## Timing
- Reset values:
  - fetch_pc = exp_pc = pc_o = RST_PC
  - os_cnt = disc_cnt = cnt = 0
  - inst_valid_o = 0, inst_o = INST_NOP, if_req_o = 0
- rst asserted in the middle of operation forces these values at the next edge. Later acks for requests issued before reset are the environment's responsibility; the bench must not send them.
- The first if_req_o is asserted in the first cycle that rst is low.
- FIFO push latency is one cycle: an ack in cycle T gives inst_valid_o = 1 in T+1. There is no ack-to-output bypass.
- Redirect in cycle T with zero wait-state memory (gnt in T+1, ack in T+2) gives valid in T+3.
- The FIFO can be full (cnt = DEPTH) and pop/push can happen in the same cycle. The credit check prevents a push into a full FIFO.
- All outputs are combinational from registers, except if_req_o, which also depends on rst and redirect_i.

## Test plan
- **Reset and stream:** rst for 3 cycles, then zero-wait memory returning addr+0x100, with inst_nxt_i held at 1.
  - pc_o steps 0,4,8,…; inst_o = 0x100,0x104,…
  - First valid appears 2 cycles after rst falls.
- **Backpressure:** DEPTH=4, inst_nxt_i = 0.
  - Exactly 4 grants occur; if_req_o stays low with cnt = 4.
  - Setting inst_nxt_i = 1 for one cycle gives one new request, with if_addr_o = 0x10.
- **Redirect with in-flight requests:** MAX_OS=2, memory ack delay 3 cycles; redirect to 0x203 while os_cnt = 2.
  - The 2 stale acks are dropped.
  - Next valid shows pc_o = 0x200 with the 0x200 data.
- **Redirect with simultaneous events:** redirect in the same cycle as an ack and an inst_nxt_i pop.
  - The FIFO is empty the next cycle, the acked data never appears, and disc_cnt = os_cnt − 1.
- **Wrap-around:** RST_PC = 0xFFFF_FFF8.
  - Fetch addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - pc_o follows the same sequence.
- **Empty-pop filler:** inst_nxt_i = 1 with an empty FIFO.
  - inst_o = 0x0000_006f, inst_valid_o = 0, and exp_pc is unchanged.

Source files
------------

// File: rtl/ifu_pf.sv
// Prefetching instruction fetch unit: issues sequential fetches ahead of
// execution, buffers in-order responses and drops stale ones after a redirect.
module ifu_pf #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         DEPTH    = 4,
  parameter int unsigned         MAX_OS   = 2,
  parameter logic [ADDR_W-1:0]   RST_PC   = '0,
  parameter logic [DATA_W-1:0]   INST_NOP = DATA_W'(32'h0000_006f)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              inst_nxt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              if_req_o,
  output logic [ADDR_W-1:0] if_addr_o,
  input  logic              if_gnt_i,
  input  logic              if_ack_i,
  input  logic [DATA_W-1:0] if_data_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OS_W  = $clog2(MAX_OS + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] exp_pc_q, exp_pc_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic [OS_W-1:0]   disc_cnt_q, disc_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [ADDR_W-1:0] redir_pc;
  logic [CNT_W:0]    credit_sum;
  logic              grant, push, pop;

  assign redir_pc   = redirect_pc_i & ~ADDR_W'(3);
  // In-flight plus buffered entries never exceed the buffer, so a push always has room.
  assign credit_sum = (CNT_W+1)'(os_cnt_q) + (CNT_W+1)'(cnt_q);

  assign if_req_o     = !rst && !redirect_i && (os_cnt_q < OS_W'(MAX_OS)) &&
                        (credit_sum < (CNT_W+1)'(DEPTH));
  assign if_addr_o    = fetch_pc_q;
  assign inst_valid_o = (cnt_q != '0);
  assign inst_o       = inst_valid_o ? mem_q[rd_ptr_q] : INST_NOP;
  assign pc_o         = exp_pc_q;

  assign grant = if_req_o && if_gnt_i;
  assign push  = if_ack_i && (disc_cnt_q == '0);
  assign pop   = inst_nxt_i && inst_valid_o;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    exp_pc_d   = exp_pc_q;
    os_cnt_d   = os_cnt_q;
    disc_cnt_d = disc_cnt_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_d      = mem_q;
    if (redirect_i) begin
      // Everything still in flight (minus an ack landing now) becomes stale.
      fetch_pc_d = redir_pc;
      exp_pc_d   = redir_pc;
      os_cnt_d   = os_cnt_q - OS_W'(if_ack_i);
      disc_cnt_d = os_cnt_q - OS_W'(if_ack_i);
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      case ({grant, if_ack_i})
        2'b10:   os_cnt_d = os_cnt_q + OS_W'(1);
        2'b01:   os_cnt_d = os_cnt_q - OS_W'(1);
        default: os_cnt_d = os_cnt_q;
      endcase
      if (if_ack_i && (disc_cnt_q != '0)) disc_cnt_d = disc_cnt_q - OS_W'(1);
      if (push) begin
        mem_d[wr_ptr_q] = if_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        exp_pc_d = exp_pc_q + ADDR_W'(4);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RST_PC;
      exp_pc_q   <= RST_PC;
      os_cnt_q   <= '0;
      disc_cnt_q <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      exp_pc_q   <= exp_pc_d;
      os_cnt_q   <= os_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage needs no reset; cnt_q gates visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
